// File: rtl/ram2p_fifo_if.sv
// rtl/ram2p_fifo_if.sv - producer/consumer handshake bundle for ram2p_fifo
interface ram2p_fifo_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             Flush;
  logic             WValid;
  logic [WIDTH-1:0] WData;
  logic             WReady;
  logic             RValid;
  logic [WIDTH-1:0] RData;
  logic             RReady;
  logic [LW-1:0]    Level;
  logic             AlmostFull;

  // Producer/consumer side.
  modport master (
    output Flush, WValid, WData, RReady,
    input  WReady, RValid, RData, Level, AlmostFull
  );

  // FIFO side.
  modport slave (
    input  Flush, WValid, WData, RReady,
    output WReady, RValid, RData, Level, AlmostFull
  );
endinterface

// File: rtl/ram2p_fifo.sv
// rtl/ram2p_fifo.sv - first-word-fall-through FIFO controlling a 1R1W two-port SRAM
// Optional occupancy outputs (Level, AlmostFull >= AFTHRESH) under macro RAMFIFO_LEVEL_EN.
module ram2p_fifo #(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 32,
  parameter int AFTHRESH = DEPTH - 4
) (
  input  logic         clk,
  input  logic         reset,
  ram2p_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (WIDTH + 7) / 8;
  localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AFTHRESH > DEPTH) begin : g_bad_params
    $error("ram2p_fifo: DEPTH must be a power of 2 >= 4 and AFTHRESH <= DEPTH");
  end

  // Controller state. count includes the entry presented on RData;
  // avail counts entries written but not yet read-issued to the SRAM.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] avail;
  logic          rvalid;

  logic full;
  logic push;
  logic pop;
  logic issue;

  // SRAM port signals.
  logic             sram_we;
  logic [AW-1:0]    sram_waddr;
  logic [WIDTH-1:0] sram_wdata;
  logic [BW-1:0]    sram_be;
  logic             sram_ce;
  logic [AW-1:0]    sram_raddr;
  logic [WIDTH-1:0] sram_rdata;
  logic [WIDTH-1:0] mem [DEPTH];

  // No bypass: a same-cycle pop does not open WReady, so full is purely registered.
  assign full  = (count == FULL_COUNT);
  assign push  = bus.WValid & ~full & ~bus.Flush;
  assign pop   = rvalid & bus.RReady & ~bus.Flush;
  // Only entries already committed at an earlier edge are issued, so the
  // read-first SRAM never sees a same-cycle read/write of one address.
  assign issue = (avail != '0) & (~rvalid | bus.RReady) & ~bus.Flush;

  assign sram_we    = push;
  assign sram_waddr = wr_ptr;
  assign sram_wdata = bus.WData;
  assign sram_be    = '1;
  assign sram_ce    = issue;
  assign sram_raddr = rd_ptr;

  // Pointer, occupancy and output-valid bookkeeping; flush outranks all traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= '0;
      rvalid <= 1'b0;
    end else if (bus.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push, issue})
        2'b10:   avail <= avail + 1'b1;
        2'b01:   avail <= avail - 1'b1;
        default: avail <= avail;
      endcase
      if (issue) begin
        rvalid <= 1'b1;
      end else if (pop) begin
        rvalid <= 1'b0;
      end
    end
  end

  // SRAM write port with per-byte lane enables.
  always_ff @(posedge clk) begin
    if (sram_we) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sram_be[i / 8]) begin
          mem[sram_waddr][i] <= sram_wdata[i];
        end
      end
    end
  end

  // SRAM read port: registered address; data holds while chip enable is low.
  always_ff @(posedge clk) begin
    if (sram_ce) begin
      sram_rdata <= mem[sram_raddr];
    end
  end

  assign bus.WReady = ~full;
  assign bus.RValid = rvalid;
  assign bus.RData  = sram_rdata;

`ifdef RAMFIFO_LEVEL_EN
  assign bus.Level      = count;
  assign bus.AlmostFull = (count >= LW'(AFTHRESH));
`else
  assign bus.Level      = '0;
  assign bus.AlmostFull = full;
`endif
endmodule

// File: tb/tb_ram2p_fifo.sv
// tb/tb_ram2p_fifo.sv - directed self-checking bench for ram2p_fifo
module tb_ram2p_fifo;
  localparam int DEPTH    = 64;
  localparam int WIDTH    = 32;
  localparam int AFTHRESH = 60;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  ram2p_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  ram2p_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFTHRESH(AFTHRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected Level for a given occupancy in this build.
  function automatic logic [63:0] exp_level(input int n);
`ifdef RAMFIFO_LEVEL_EN
    return 64'(n);
`else
    return 64'(0 * n);
`endif
  endfunction

  // Expected AlmostFull for a given occupancy in this build.
  function automatic logic [63:0] exp_af(input int n);
`ifdef RAMFIFO_LEVEL_EN
    return (n >= AFTHRESH) ? 64'd1 : 64'd0;
`else
    return (n == DEPTH) ? 64'd1 : 64'd0;
`endif
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int pushed;
    int popped;
    bit wv;
    bit rr;
    bit held;
    logic [31:0] held_data;

    reset      = 1'b1;
    bus.Flush  = 1'b0;
    bus.WValid = 1'b0;
    bus.WData  = '0;
    bus.RReady = 1'b0;

    // Reset state
    tick;
    check("rst_wready", bus.WReady, 1);
    check("rst_rvalid", bus.RValid, 0);
    check("rst_level", bus.Level, exp_level(0));
    check("rst_af", bus.AlmostFull, exp_af(0));
    reset = 1'b0;

    // Single push: cycle 1 push, RValid in cycle 3
    bus.WValid = 1'b1;
    bus.WData  = 32'hA5A5_0001;
    tick;
    bus.WValid = 1'b0;
    check("t1_c2_rvalid", bus.RValid, 0);
    check("t1_c2_wready", bus.WReady, 1);
    tick;
    check("t1_c3_rvalid", bus.RValid, 1);
    check("t1_c3_rdata", bus.RData, 32'hA5A5_0001);
    check("t1_c3_wready", bus.WReady, 1);
    bus.RReady = 1'b1;
    tick;
    bus.RReady = 1'b0;
    check("t1_empty", bus.RValid, 0);

    // Fill to DEPTH with RReady low
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_wready_fill", bus.WReady, 1);
      bus.WValid = 1'b1;
      bus.WData  = 32'(i);
      tick;
    end
    check("t2_full_wready", bus.WReady, 0);
    check("t2_full_af", bus.AlmostFull, exp_af(DEPTH));
    check("t2_full_level", bus.Level, exp_level(DEPTH));
    bus.WData = 32'hDEAD_BEEF;
    tick;
    bus.WValid = 1'b0;
    check("t2_full_hold", bus.WReady, 0);
    check("t2_head_valid", bus.RValid, 1);
    check("t2_head_data", bus.RData, 0);

    // Drain with no bubbles; WReady returns the cycle after the first pop
    bus.RReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_valid", bus.RValid, 1);
      check("t2_drain_data", bus.RData, 64'(i));
      if (i == 0) check("t2_wready_first_pop", bus.WReady, 0);
      if (i == 1) check("t2_wready_after_pop", bus.WReady, 1);
      tick;
    end
    check("t2_drained", bus.RValid, 0);
    check("t2_level_zero", bus.Level, exp_level(0));
    bus.RReady = 1'b0;

    // Streaming push and pop for 200 cycles
    pops = 0;
    bus.RReady = 1'b1;
    for (int c = 0; c < 200; c++) begin
      bus.WValid = 1'b1;
      bus.WData  = 32'h1000 + 32'(c);
      tick;
      if (c == 0) begin
        check("t3_fill_bubble", bus.RValid, 0);
      end else begin
        check("t3_stream_valid", bus.RValid, 1);
        check("t3_stream_level", bus.Level, exp_level(2));
        check("t3_stream_wready", bus.WReady, 1);
      end
      if (bus.RValid) begin
        check("t3_stream_data", bus.RData, 64'(32'h1000 + 32'(pops)));
        pops++;
      end
    end
    bus.WValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bus.RValid) begin
        check("t3_tail_data", bus.RData, 64'(32'h1000 + 32'(pops)));
        pops++;
      end
    end
    check("t3_pop_count", pops, 200);
    bus.RReady = 1'b0;

    // Random producer/consumer backpressure
    pushed = 0;
    popped = 0;
    held   = 1'b0;
    held_data = '0;
    for (int c = 0; c < 600 && popped < 30; c++) begin
      if (bus.RValid) begin
        if (held) check("t4_rdata_stable", bus.RData, held_data);
        check("t4_order", bus.RData, 64'(32'h5000 + 32'(popped)));
      end
      wv = (pushed < 30) && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 1) == 1);
      bus.WValid = wv;
      bus.WData  = 32'h5000 + 32'(pushed);
      bus.RReady = rr;
      if (wv && bus.WReady) pushed++;
      held      = bus.RValid && !rr;
      held_data = bus.RData;
      if (bus.RValid && rr) popped++;
      tick;
    end
    bus.WValid = 1'b0;
    bus.RReady = 1'b0;
    check("t4_popped", popped, 30);
    check("t4_empty", bus.RValid, 0);

    // Flush with 10 entries and a same-cycle push
    for (int i = 0; i < 10; i++) begin
      bus.WValid = 1'b1;
      bus.WData  = 32'h6000 + 32'(i);
      tick;
    end
    bus.Flush = 1'b1;
    bus.WData = 32'h0000_0BAD;
    tick;
    bus.Flush  = 1'b0;
    bus.WValid = 1'b0;
    check("t5_rvalid", bus.RValid, 0);
    check("t5_wready", bus.WReady, 1);
    check("t5_level", bus.Level, exp_level(0));
    check("t5_af", bus.AlmostFull, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t5_dropped", bus.RValid, 0);
    end
    bus.WValid = 1'b1;
    bus.WData  = 32'h0000_0077;
    tick;
    bus.WValid = 1'b0;
    tick;
    check("t5_after_valid", bus.RValid, 1);
    check("t5_after_data", bus.RData, 32'h77);
    bus.RReady = 1'b1;
    tick;
    bus.RReady = 1'b0;
    check("t5_after_empty", bus.RValid, 0);

    // AlmostFull threshold
    for (int i = 0; i < AFTHRESH - 1; i++) begin
      bus.WValid = 1'b1;
      bus.WData  = 32'(i);
      tick;
    end
    check("t6_59_af", bus.AlmostFull, exp_af(AFTHRESH - 1));
    check("t6_59_level", bus.Level, exp_level(AFTHRESH - 1));
    bus.WData = 32'(AFTHRESH - 1);
    tick;
    bus.WValid = 1'b0;
    check("t6_60_af", bus.AlmostFull, exp_af(AFTHRESH));
    check("t6_60_level", bus.Level, exp_level(AFTHRESH));
    bus.RReady = 1'b1;
    tick;
    bus.RReady = 1'b0;
    check("t6_pop_af", bus.AlmostFull, exp_af(AFTHRESH - 1));
    check("t6_pop_level", bus.Level, exp_level(AFTHRESH - 1));
    check("t6_head_data", bus.RData, 1);
    bus.Flush = 1'b1;
    tick;
    bus.Flush = 1'b0;
    check("t6_flushed", bus.RValid, 0);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      bus.WValid = 1'b1;
      bus.WData  = 32'h9000 + 32'(i);
      tick;
    end
    bus.WValid = 1'b0;
    check("t7_pre_valid", bus.RValid, 1);
    #2 reset = 1'b1;
    #1;
    check("t7_async_rvalid", bus.RValid, 0);
    check("t7_async_wready", bus.WReady, 1);
    check("t7_async_level", bus.Level, exp_level(0));
    tick;
    reset = 1'b0;
    tick;
    tick;
    check("t7_discarded", bus.RValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
